// File: rtl/fxp_pkg.sv
// Shared constants and helpers for the pipelined fixed-point multiplier.
// Limits are returned at a fixed wide width; callers size-cast to their own width.
package fxp_pkg;
  localparam int MODE_ROUND = 0;
  localparam int MODE_SAT   = 1;
  localparam int LIM_W      = 256;

  function automatic int prod_w(input int data_w);
    return 2 * data_w;
  endfunction

  function automatic logic signed [LIM_W-1:0] fxp_max(input int w);
    return (LIM_W'(1) <<< (w - 1)) - LIM_W'(1);
  endfunction

  function automatic logic signed [LIM_W-1:0] fxp_min(input int w);
    return ~fxp_max(w);
  endfunction
endpackage

// File: rtl/fxp_round_sat.sv
// Scales a full-width signed product by 2^-FRAC_W (truncate toward zero or
// round half away from zero) and applies wrap/saturate overflow handling.
module fxp_round_sat
  import fxp_pkg::*;
#(
  parameter int DATA_W = 77,
  parameter int FRAC_W = 16
) (
  input  logic signed [prod_w(DATA_W)-1:0] prod,
  input  logic        [1:0]                mode,
  output logic        [DATA_W-1:0]         p,
  output logic                             ovf
);
  localparam int PW = prod_w(DATA_W);
  localparam int EW = PW + 1;
  localparam logic        [EW-1:0] HALF = EW'(1) << (FRAC_W - 1);
  localparam logic signed [EW-1:0] LMAX = EW'(fxp_max(DATA_W));
  localparam logic signed [EW-1:0] LMIN = EW'(fxp_min(DATA_W));

  logic                 neg;
  logic        [EW-1:0] mag;
  logic        [EW-1:0] smag;
  logic signed [EW-1:0] sc;

  // Work on the magnitude so both modes are symmetric about zero.
  always_comb begin
    neg  = prod[PW-1];
    mag  = neg ? -{1'b1, prod} : {1'b0, prod};
    smag = (mag + (mode[MODE_ROUND] ? HALF : '0)) >> FRAC_W;
    sc   = neg ? -$signed(smag) : $signed(smag);
    ovf  = (sc > LMAX) || (sc < LMIN);
    if (ovf && mode[MODE_SAT]) p = neg ? LMIN[DATA_W-1:0] : LMAX[DATA_W-1:0];
    else                       p = sc[DATA_W-1:0];
  end
endmodule

// File: rtl/fxp_mult_pipe.sv
// Pipelined signed fixed-point multiplier with global-stall valid/ready flow,
// per-transaction round/saturate mode and a saturating overflow counter.
module fxp_mult_pipe
  import fxp_pkg::*;
#(
  parameter int DATA_W = 77,
  parameter int FRAC_W = 16,
  parameter int STAGES = 3,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_a,
  input  logic signed [DATA_W-1:0] in_b,
  input  logic        [1:0]        in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_p,
  output logic                     out_ovf,
  output logic        [CNT_W-1:0]  ovf_cnt,
  input  logic                     ovf_clr
);
  localparam int PW = prod_w(DATA_W);

  logic                     adv;
  logic [STAGES:1]          vld_pipe;
  logic signed [DATA_W-1:0] a_q, b_q;
  logic        [1:0]        mode_q;
  logic signed [PW-1:0]     prod_c;
  logic signed [PW-1:0]     rs_prod;
  logic        [1:0]        rs_mode;
  logic        [DATA_W-1:0] rs_p;
  logic                     rs_ovf;

  assign adv       = !(out_valid && !out_ready);
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)   vld_pipe <= '0;
    else if (adv) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= '0;
    end else if (adv && in_valid) begin
      a_q    <= in_a;
      b_q    <= in_b;
      mode_q <= in_mode;
    end

  assign prod_c = $signed({{DATA_W{a_q[DATA_W-1]}}, a_q}) *
                  $signed({{DATA_W{b_q[DATA_W-1]}}, b_q});

  generate
    if (STAGES == 2) begin : g_merge
      assign rs_prod = prod_c;
      assign rs_mode = mode_q;
    end else begin : g_pipe
      // Product register plus STAGES-3 retiming delays.
      logic signed [PW-1:0] prod_q  [STAGES-2];
      logic        [1:0]    pmode_q [STAGES-2];

      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          for (int i = 0; i < STAGES - 2; i++) begin
            prod_q[i]  <= '0;
            pmode_q[i] <= '0;
          end
        end else if (adv) begin
          prod_q[0]  <= prod_c;
          pmode_q[0] <= mode_q;
          for (int i = 1; i < STAGES - 2; i++) begin
            prod_q[i]  <= prod_q[i-1];
            pmode_q[i] <= pmode_q[i-1];
          end
        end

      assign rs_prod = prod_q[STAGES-3];
      assign rs_mode = pmode_q[STAGES-3];
    end
  endgenerate

  fxp_round_sat #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_round_sat (
    .prod (rs_prod),
    .mode (rs_mode),
    .p    (rs_p),
    .ovf  (rs_ovf)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_p   <= '0;
      out_ovf <= 1'b0;
    end else if (adv && vld_pipe[STAGES-1]) begin
      out_p   <= rs_p;
      out_ovf <= rs_ovf;
    end

  // Clear has priority over a coincident increment.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)       ovf_cnt <= '0;
    else if (ovf_clr) ovf_cnt <= '0;
    else if (out_valid && out_ready && out_ovf && !(&ovf_cnt))
      ovf_cnt <= ovf_cnt + CNT_W'(1);
endmodule

// File: tb/tb_fxp_mult_pipe.sv
// Self-checking bench for fxp_mult_pipe: directed vectors plus randomized
// streams scored against an arithmetic reference model.
module tb_fxp_mult_pipe;
  import fxp_pkg::*;
  localparam int W  = 77;
  localparam int F  = 16;
  localparam int MW = 2 * W + 4;
  localparam logic signed [W-1:0] MAXP  = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MINN  = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] WRAPV = {{(W-1){1'b1}}, 1'b0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b1, ovf_clr = 1'b0;
  logic signed [W-1:0] in_a = '0, in_b = '0;
  logic [1:0] in_mode = '0;
  logic in_ready, out_valid, out_ovf;
  logic signed [W-1:0] out_p;
  logic [15:0] ovf_cnt;
  logic in_ready2, out_valid2, out_ovf2;
  logic signed [W-1:0] out_p2;
  logic [1:0] ovf_cnt2;

  int checks = 0;
  int failures = 0;

  typedef struct packed { logic [W-1:0] p; logic ovf; } exp_t;
  exp_t sb[$];

  fxp_mult_pipe #(.DATA_W(W), .FRAC_W(F), .STAGES(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_p(out_p), .out_ovf(out_ovf),
    .ovf_cnt(ovf_cnt), .ovf_clr(ovf_clr));

  fxp_mult_pipe #(.DATA_W(W), .FRAC_W(F), .STAGES(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid2),
    .out_ready(out_ready), .out_p(out_p2), .out_ovf(out_ovf2),
    .ovf_cnt(ovf_cnt2), .ovf_clr(ovf_clr));

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference: exact integer arithmetic with signed division.
  function automatic exp_t model(input logic signed [W-1:0] a,
                                 input logic signed [W-1:0] b,
                                 input logic [1:0] m);
    logic signed [MW-1:0] pr, dv, s, mx, mn;
    exp_t e;
    pr = a;
    s  = b;
    pr = pr * s;
    dv = 1;
    dv = dv <<< F;
    if (m[MODE_ROUND]) begin
      s = (pr < 0) ? -pr : pr;
      s = (s + dv / 2) / dv;
      if (pr < 0) s = -s;
    end else begin
      s = pr / dv;
    end
    mx = 1;
    mx = (mx <<< (W - 1)) - 1;
    mn = -mx - 1;
    e.ovf = (s > mx) || (s < mn);
    if (e.ovf && m[MODE_SAT]) e.p = (s > mx) ? mx[W-1:0] : mn[W-1:0];
    else                      e.p = s[W-1:0];
    return e;
  endfunction

  function automatic logic signed [W-1:0] rnd_op();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    case ($urandom_range(0, 5))
      0:       return {{(W-24){r[23]}}, r[23:0]};
      1:       return {{(W-48){r[47]}}, r[47:0]};
      2:       return r[W-1:0];
      3:       return MAXP;
      4:       return MINN;
      default: return {{(W-40){r[39]}}, r[39:0]};
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic issue(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                       input logic [1:0] m);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_mode = m;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Returns at negedge+1 of the cycle showing out_valid; lat counts from acceptance.
  task automatic wait_out(output int lat);
    lat = 1;
    repeat (20) begin
      #1;
      if (out_valid === 1'b1) return;
      @(negedge clk);
      lat++;
    end
    lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_p !== '0) begin failures++; $display("FAIL reset_p got=%h exp=0", out_p); end
    checks++; if (out_ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", out_ovf); end
    checks++; if (ovf_cnt !== '0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", ovf_cnt); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic();
    int lat;
    do_reset();
    issue(77'sh18000, 77'sh20000, 2'b00);
    wait_out(lat);
    checks++; if (lat != 3) begin failures++; $display("FAIL basic_latency got=%0d exp=3", lat); end
    checks++; if (out_p !== 77'sh30000) begin failures++; $display("FAIL basic_p got=%h exp=%h", out_p, 77'sh30000); end
    checks++; if (out_ovf !== 1'b0) begin failures++; $display("FAIL basic_ovf got=%b exp=0", out_ovf); end
    @(negedge clk);
  endtask

  task automatic test_rounding();
    logic signed [W-1:0] va [4];
    logic [1:0] vm [4];
    logic [W-1:0] ep [4];
    int k = 0;
    va[0] = -1; va[1] = -1; va[2] = 3; va[3] = 3;
    vm[0] = 2'b00; vm[1] = 2'b01; vm[2] = 2'b01; vm[3] = 2'b00;
    ep[0] = '0; ep[1] = '1; ep[2] = 2; ep[3] = 1;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c < 4) begin
        in_valid = 1'b1; in_a = va[c]; in_b = 77'sh8000; in_mode = vm[c];
      end else in_valid = 1'b0;
      #1;
      if (out_valid) begin
        checks++;
        if (k >= 4 || c != k + 3 || out_p !== ep[k] || out_ovf !== 1'b0) begin
          failures++;
          $display("FAIL round_%0d cycle=%0d got=%h/%b exp=%h/0", k, c, out_p, out_ovf, ep[k & 3]);
        end
        k++;
      end
    end
    checks++; if (k != 4) begin failures++; $display("FAIL round_count got=%0d exp=4", k); end
  endtask

  task automatic test_overflow();
    logic signed [W-1:0] va [6], vb [6];
    logic [1:0] vm [6];
    logic [W-1:0] ep [6];
    logic eo [6];
    int lat, exp_cnt = 0;
    va[0] = MAXP; vb[0] = 77'sh20000; vm[0] = 2'b10; ep[0] = MAXP;  eo[0] = 1'b1;
    va[1] = MAXP; vb[1] = 77'sh20000; vm[1] = 2'b00; ep[1] = WRAPV; eo[1] = 1'b1;
    va[2] = MINN; vb[2] = 77'sh20000; vm[2] = 2'b11; ep[2] = MINN;  eo[2] = 1'b1;
    va[3] = MINN; vb[3] = 77'sh20000; vm[3] = 2'b00; ep[3] = '0;    eo[3] = 1'b1;
    va[4] = MAXP; vb[4] = 77'sh10000; vm[4] = 2'b10; ep[4] = MAXP;  eo[4] = 1'b0;
    va[5] = MINN; vb[5] = 77'sh10000; vm[5] = 2'b11; ep[5] = MINN;  eo[5] = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      issue(va[i], vb[i], vm[i]);
      wait_out(lat);
      checks++;
      if (lat != 3 || out_p !== ep[i] || out_ovf !== eo[i]) begin
        failures++;
        $display("FAIL ovf_vec%0d lat=%0d got=%h/%b exp=%h/%b", i, lat, out_p, out_ovf, ep[i], eo[i]);
      end
      if (eo[i]) exp_cnt++;
      @(negedge clk); #1;
      checks++; if (ovf_cnt !== 16'(exp_cnt)) begin failures++; $display("FAIL ovf_cnt%0d got=%0d exp=%0d", i, ovf_cnt, exp_cnt); end
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0, got = 0, c = 0;
    logic need_new = 1'b1, stall_prev = 1'b0;
    logic [W-1:0] p_prev = '0;
    exp_t e;
    do_reset();
    while ((sent < 10 || sb.size() != 0) && c < 200) begin
      @(negedge clk);
      if (need_new) begin
        in_a = rnd_op(); in_b = rnd_op(); in_mode = 2'($urandom_range(0, 3));
        need_new = 1'b0;
      end
      out_ready = (c % 4 == 0) || (c % 4 == 3);
      in_valid  = (sent < 10);
      #1;
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        failures++; $display("FAIL b2b_ready cycle=%0d got=%b exp=%b", c, in_ready, !(out_valid && !out_ready));
      end
      if (stall_prev) begin
        checks++;
        if (out_valid !== 1'b1 || out_p !== p_prev) begin
          failures++; $display("FAIL b2b_stable cycle=%0d got=%h exp=%h", c, out_p, p_prev);
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(in_a, in_b, in_mode)); sent++; need_new = 1'b1;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL b2b_extra cycle=%0d got=%h exp=none", c, out_p); end
        else begin
          e = sb.pop_front();
          if (out_p !== e.p || out_ovf !== e.ovf) begin
            failures++; $display("FAIL b2b_result%0d got=%h/%b exp=%h/%b", got, out_p, out_ovf, e.p, e.ovf);
          end
        end
        got++;
      end
      stall_prev = out_valid && !out_ready;
      p_prev = out_p;
      c++;
    end
    checks++; if (got != 10) begin failures++; $display("FAIL b2b_count got=%0d exp=10", got); end
    out_ready = 1'b1; in_valid = 1'b0;
  endtask

  task automatic test_random();
    int sent = 0, c = 0, novf = 0;
    logic need_new = 1'b1, stall_prev = 1'b0;
    logic [W-1:0] p_prev = '0;
    exp_t e;
    do_reset();
    while ((sent < 200 || sb.size() != 0) && c < 3000) begin
      @(negedge clk);
      if (need_new) begin
        in_a = rnd_op(); in_b = rnd_op(); in_mode = 2'($urandom_range(0, 3));
        need_new = 1'b0;
      end
      in_valid  = (sent < 200) && ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        failures++; $display("FAIL rnd_ready cycle=%0d got=%b exp=%b", c, in_ready, !(out_valid && !out_ready));
      end
      if (stall_prev) begin
        checks++;
        if (out_valid !== 1'b1 || out_p !== p_prev) begin
          failures++; $display("FAIL rnd_stable cycle=%0d got=%h exp=%h", c, out_p, p_prev);
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(in_a, in_b, in_mode)); sent++; need_new = 1'b1;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL rnd_extra cycle=%0d got=%h exp=none", c, out_p); end
        else begin
          e = sb.pop_front();
          if (e.ovf) novf++;
          if (out_p !== e.p || out_ovf !== e.ovf) begin
            failures++; $display("FAIL rnd_result cycle=%0d got=%h/%b exp=%h/%b", c, out_p, out_ovf, e.p, e.ovf);
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      p_prev = out_p;
      c++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk); #1;
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL rnd_drain got=%0d pending exp=0", sb.size()); end
    checks++; if (ovf_cnt !== 16'(novf)) begin failures++; $display("FAIL rnd_ovf_cnt got=%0d exp=%0d", ovf_cnt, novf); end
  endtask

  task automatic test_reset_midstream();
    int lat, stale = 0;
    logic signed [W-1:0] a, b;
    exp_t e;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = 77'sh18000 + W'(i); in_b = 77'sh20000; in_mode = 2'b00;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_inflight got=%b exp=1", out_valid); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_p !== '0 || out_ovf !== 1'b0) begin
      failures++; $display("FAIL mid_reset got=%b/%h/%b exp=0/0/0", out_valid, out_p, out_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk); #1;
      if (out_valid !== 1'b0) stale++;
    end
    checks++; if (stale != 0) begin failures++; $display("FAIL mid_stale got=%0d exp=0", stale); end
    a = rnd_op(); b = rnd_op();
    e = model(a, b, 2'b11);
    issue(a, b, 2'b11);
    wait_out(lat);
    checks++;
    if (lat != 3 || out_p !== e.p || out_ovf !== e.ovf) begin
      failures++; $display("FAIL mid_after lat=%0d got=%h/%b exp=%h/%b", lat, out_p, out_ovf, e.p, e.ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_counter();
    int lat;
    do_reset();
    repeat (2) begin
      issue(MAXP, 77'sh20000, 2'b00);
      wait_out(lat);
      @(negedge clk);
    end
    #1;
    checks++; if (ovf_cnt !== 16'd2) begin failures++; $display("FAIL cnt_two got=%0d exp=2", ovf_cnt); end
    issue(MAXP, 77'sh20000, 2'b00);
    wait_out(lat);
    checks++;
    if (out_valid2 !== 1'b1 || in_ready2 !== 1'b1 || out_p2 !== WRAPV || out_ovf2 !== 1'b1) begin
      failures++; $display("FAIL cnt_dut2_out got=%b/%b/%h/%b exp=1/1/%h/1", out_valid2, in_ready2, out_p2, out_ovf2, WRAPV);
    end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    #1;
    checks++; if (ovf_cnt !== 16'd0) begin failures++; $display("FAIL cnt_clr_wins got=%0d exp=0", ovf_cnt); end
    checks++; if (ovf_cnt2 !== 2'd0) begin failures++; $display("FAIL cnt2_clr got=%0d exp=0", ovf_cnt2); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = MAXP; in_b = 77'sh20000; in_mode = 2'($urandom_range(0, 3));
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    checks++; if (ovf_cnt !== 16'd5) begin failures++; $display("FAIL cnt_five got=%0d exp=5", ovf_cnt); end
    checks++; if (ovf_cnt2 !== 2'd3) begin failures++; $display("FAIL cnt2_sat got=%0d exp=3", ovf_cnt2); end
    issue(MINN, 77'sh20000, 2'b10);
    wait_out(lat);
    @(negedge clk); #1;
    checks++; if (ovf_cnt !== 16'd6) begin failures++; $display("FAIL cnt_six got=%0d exp=6", ovf_cnt); end
    checks++; if (ovf_cnt2 !== 2'd3) begin failures++; $display("FAIL cnt2_hold got=%0d exp=3", ovf_cnt2); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_overflow();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    test_counter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
